// File: rtl/u_rom_loader.sv
// u_rom_loader: rebuilds control words from a framed byte stream and writes them to microcode RAM
// Frame: ADDR_L ADDR_H CNT_L CNT_H, CNT*CW_BYTES data bytes, CHK (XOR of all prior frame bytes).
// Ports: start/in_data/in_valid/in_ready = byte link; uc_we/uc_addr/uc_wdata = RAM write port;
//        busy/done = frame status; chk_err/wrap_err = checksum and address-wrap flags of the last frame.
module u_rom_loader #(
  parameter int CW_BYTES   = 14,
  parameter int CW_WIDTH   = 8*CW_BYTES,
  parameter int ADDR_WIDTH = 14
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [7:0]            in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic                  uc_we,
  output logic [ADDR_WIDTH-1:0] uc_addr,
  output logic [CW_WIDTH-1:0]   uc_wdata,
  output logic                  busy,
  output logic                  done,
  output logic                  chk_err,
  output logic                  wrap_err
);
  localparam int IW = $clog2(CW_BYTES);
  typedef enum logic [2:0] {IDLE, HDR, DATA, WRITE, CHK, DONE} state_t;
  state_t                state_q, state_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d, uc_addr_q, uc_addr_d;
  logic [15:0]           cnt_q, cnt_d;
  logic [7:0]            xor_q, xor_d;
  logic [CW_WIDTH-1:0]   word_q, word_d, uc_wdata_q, uc_wdata_d;
  logic                  chk_err_q, chk_err_d, wrap_err_q, wrap_err_d;
  logic                  acc;
  assign in_ready = state_q == HDR || state_q == DATA || state_q == CHK;
  assign acc      = in_valid & in_ready;
  assign uc_we    = state_q == WRITE;
  assign busy     = state_q != IDLE;
  assign done     = state_q == DONE;
  assign uc_addr  = uc_addr_q;
  assign uc_wdata = uc_wdata_q;
  assign chk_err  = chk_err_q;
  assign wrap_err = wrap_err_q;
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    addr_d     = addr_q;
    cnt_d      = cnt_q;
    xor_d      = xor_q;
    word_d     = word_q;
    uc_addr_d  = uc_addr_q;
    uc_wdata_d = uc_wdata_q;
    chk_err_d  = chk_err_q;
    wrap_err_d = wrap_err_q;
    case (state_q)
      IDLE: if (start) begin
        state_d    = HDR;
        idx_d      = '0;
        xor_d      = '0;
        chk_err_d  = 1'b0;
        wrap_err_d = 1'b0;
      end
      HDR: if (acc) begin
        xor_d = xor_q ^ in_data;
        idx_d = idx_q + 1'b1;
        if (idx_q == IW'(0)) addr_d[7:0] = in_data;
        else if (idx_q == IW'(1)) addr_d = ADDR_WIDTH'({in_data, addr_q[7:0]});
        else if (idx_q == IW'(2)) cnt_d[7:0] = in_data;
        else begin
          cnt_d[15:8] = in_data;
          idx_d       = '0;
          state_d     = {in_data, cnt_q[7:0]} == 16'd0 ? CHK : DATA;
        end
      end
      DATA: if (acc) begin
        xor_d                 = xor_q ^ in_data;
        word_d[8*idx_q +: 8]  = in_data;
        idx_d                 = idx_q + 1'b1;
        if (idx_q == IW'(CW_BYTES-1)) begin
          idx_d      = '0;
          state_d    = WRITE;
          uc_addr_d  = addr_q;
          uc_wdata_d = word_d;
        end
      end
      WRITE: begin
        addr_d     = addr_q + 1'b1;
        cnt_d      = cnt_q - 1'b1;
        wrap_err_d = wrap_err_q | (&addr_q && cnt_q != 16'd1);
        state_d    = cnt_q == 16'd1 ? CHK : DATA;
      end
      CHK: if (acc) begin
        chk_err_d = in_data != xor_q;
        state_d   = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      addr_q     <= '0;
      cnt_q      <= '0;
      xor_q      <= '0;
      word_q     <= '0;
      uc_addr_q  <= '0;
      uc_wdata_q <= '0;
      chk_err_q  <= 1'b0;
      wrap_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      addr_q     <= addr_d;
      cnt_q      <= cnt_d;
      xor_q      <= xor_d;
      word_q     <= word_d;
      uc_addr_q  <= uc_addr_d;
      uc_wdata_q <= uc_wdata_d;
      chk_err_q  <= chk_err_d;
      wrap_err_q <= wrap_err_d;
    end
  end
endmodule

// File: tb/tb_u_rom_loader.sv
// tb_u_rom_loader: table-driven and randomized frames checked against a word-list model
module tb_u_rom_loader;
  logic         clk = 0, rst, start, in_valid, in_ready, uc_we, busy, done, chk_err, wrap_err;
  logic [7:0]   in_data;
  logic [13:0]  uc_addr;
  logic [111:0] uc_wdata;
  int total = 0, bad = 0;
  typedef struct {logic [13:0] a; logic [111:0] d;} wr_t;
  typedef struct {logic [15:0] a; logic [15:0] cnt; bit seq, badc, bs; int gap; bit e_chk, e_wrap;} vec_t;
  wr_t got[$], exp_q[$];
  vec_t tbl[8];
  u_rom_loader dut (
    .clk(clk), .rst(rst), .start(start), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .uc_we(uc_we), .uc_addr(uc_addr), .uc_wdata(uc_wdata),
    .busy(busy), .done(done), .chk_err(chk_err), .wrap_err(wrap_err)
  );
  always #5 clk = ~clk;
  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask
  always @(negedge clk) if (uc_we === 1'b1) begin
    got.push_back('{uc_addr, uc_wdata});
    check("ready_low_in_write", in_ready, 0);
  end
  task automatic check_reset();
    check("rst_in_ready", in_ready, 0);
    check("rst_uc_we", uc_we, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_chk_err", chk_err, 0);
    check("rst_wrap_err", wrap_err, 0);
    check("rst_uc_addr", uc_addr, 0);
    check("rst_uc_wdata", uc_wdata, 0);
  endtask
  task automatic send_byte(input logic [7:0] b, input int gap);
    int n = 0;
    while ($urandom_range(99) < gap) begin
      in_valid = 0;
      @(negedge clk);
    end
    in_data = b;
    in_valid = 1;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      total++;
      bad++;
      $display("FAIL byte_timeout: got in_ready=0 expected 1 within 50 cycles");
    end
    @(negedge clk);
    in_valid = 0;
  endtask
  task automatic run_frame(input vec_t v);
    logic [7:0]   x = 0, b;
    logic [111:0] w = 0;
    logic [13:0]  ea = v.a[13:0];
    logic [15:0]  h = 0;
    got.delete();
    exp_q.delete();
    start = 1;
    @(negedge clk);
    start = 0;
    check("busy_after_start", busy, 1);
    check("chk_err_cleared", chk_err, 0);
    check("wrap_err_cleared", wrap_err, 0);
    for (int k = 0; k < 4; k++) begin
      h = k < 2 ? v.a : v.cnt;
      b = k[0] ? h[15:8] : h[7:0];
      x ^= b;
      send_byte(b, v.gap);
      if (v.bs && k == 1) begin
        start = 1;
        @(negedge clk);
        start = 0;
      end
    end
    for (int i = 0; i < int'(v.cnt); i++) begin
      for (int j = 0; j < 14; j++) begin
        b = v.seq ? 8'(j + 1) : 8'($urandom);
        w[8*j +: 8] = b;
        x ^= b;
        send_byte(b, v.gap);
      end
      exp_q.push_back('{ea, w});
      ea = ea + 1'b1;
    end
    send_byte(v.badc ? x ^ 8'h01 : x, v.gap);
    check("done_pulse", done, 1);
    check("busy_in_done", busy, 1);
    @(negedge clk);
    check("done_cleared", done, 0);
    check("busy_cleared", busy, 0);
    check("write_count", got.size(), exp_q.size());
    for (int i = 0; i < got.size() && i < exp_q.size(); i++) begin
      check("write_addr", got[i].a, exp_q[i].a);
      check("write_data", got[i].d, exp_q[i].d);
    end
    check("chk_err", chk_err, v.e_chk);
    check("wrap_err", wrap_err, v.e_wrap);
  endtask
  initial begin
    vec_t v;
    rst = 1; start = 0; in_valid = 0; in_data = 0;
    repeat (3) @(negedge clk);
    check_reset();
    rst = 0;
    @(negedge clk);
    tbl[0] = '{16'h0010, 16'd1, 1, 0, 0, 0,  0, 0};
    tbl[1] = '{16'h0100, 16'd3, 0, 0, 0, 50, 0, 0};
    tbl[2] = '{16'h0042, 16'd0, 0, 0, 0, 0,  0, 0};
    tbl[3] = '{16'h0005, 16'd2, 0, 1, 0, 20, 1, 0};
    tbl[4] = '{16'h3FFF, 16'd2, 0, 0, 0, 0,  0, 1};
    tbl[5] = '{16'h3FFE, 16'd2, 0, 0, 0, 0,  0, 0};
    tbl[6] = '{16'hFFFF, 16'd1, 0, 0, 0, 0,  0, 0};
    tbl[7] = '{16'h1234, 16'd1, 0, 0, 1, 30, 0, 0};
    for (int t = 0; t < 8; t++) run_frame(tbl[t]);
    for (int r = 0; r < 12; r++) begin
      v.a = 16'($urandom);
      if (r % 3 == 0) v.a[13:0] = 14'h3FFE;
      v.cnt = 16'($urandom_range(0, 3));
      v.seq = 0;
      v.badc = 1'($urandom_range(0, 1));
      v.bs = 1'($urandom_range(0, 1));
      v.gap = $urandom_range(0, 60);
      v.e_chk = v.badc;
      v.e_wrap = v.cnt > 0 && int'(v.a[13:0]) + int'(v.cnt) - 1 > 16383;
      run_frame(v);
    end
    run_frame('{16'h0300, 16'd1, 0, 1, 0, 0, 1, 0});
    repeat (3) @(negedge clk);
    check("chk_err_held", chk_err, 1);
    got.delete();
    start = 1;
    @(negedge clk);
    start = 0;
    send_byte(8'h00, 0); send_byte(8'h02, 0); send_byte(8'h02, 0); send_byte(8'h00, 0);
    for (int j = 0; j < 21; j++) send_byte(8'($urandom), 0);
    rst = 1; in_valid = 1; in_data = 8'hAA;
    @(negedge clk);
    rst = 0; in_valid = 0;
    check_reset();
    repeat (5) @(negedge clk);
    check("writes_before_reset", got.size(), 1);
    check("idle_after_reset", busy, 0);
    run_frame('{16'h0400, 16'd2, 0, 0, 0, 25, 0, 0});
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
